// File: rtl/jt49_bus_seq.sv
// jt49_bus_seq: queues host register writes and replays them as BDIR/BC1 phases.
// Define JT49_BUS_SEQ_READ_EN to add the BC1 register read path.
module jt49_bus_seq #(
  parameter int HOLD    = 2,
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
`ifdef JT49_BUS_SEQ_READ_EN
  input  logic       rd_req,
  input  logic [3:0] rd_addr,
  output logic       rd_ready,
  input  logic [7:0] psg_dout,
  output logic       rd_valid,
  output logic [7:0] rd_data,
`endif
  output logic       busy,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] bus_dout
);

  localparam int HL    = (HOLD < 2) ? 2 : HOLD;
  localparam int PW    = $clog2(HL);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(HL - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LATCH, GAP1, WRITE, GAP2
`ifdef JT49_BUS_SEQ_READ_EN
    , READ
`endif
  } state_t;

  state_t             state, state_n;
  logic [PW-1:0]      ph, ph_n;
  logic [11:0]        cur, cur_n;
  logic [11:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [CW-1:0]      cnt, cnt_n;
  logic               push, pop;
  logic               bdir_n, bc1_n;
  logic [7:0]         dout_n;
`ifdef JT49_BUS_SEQ_READ_EN
  logic               rdop, rdop_n;
  logic               rdv_n;
  logic [7:0]         rdd_n;
`endif

  assign push = wr_valid & wr_ready;

  // FIFO storage; occupancy lives in cnt so no reset is needed here
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {wr_addr, wr_data};
  end

  // Occupancy update; simultaneous push and pop leaves it unchanged
  always_comb begin
    cnt_n = cnt;
    unique case (1'b1)
      (push && !pop): cnt_n = cnt + CW'(1);
      (!push && pop): cnt_n = cnt - CW'(1);
      default: ;
    endcase
  end

  // Next state, phase counter and transaction capture
  always_comb begin
    state_n = state;
    ph_n    = ph;
    cur_n   = cur;
    pop     = 1'b0;
`ifdef JT49_BUS_SEQ_READ_EN
    rdop_n  = rdop;
    rdv_n   = 1'b0;
    rdd_n   = rd_data;
`endif
    unique case (state)
      IDLE, GAP2: begin
        state_n = IDLE;
        ph_n    = '0;
        if (cnt != '0) begin
          pop     = 1'b1;
          state_n = LATCH;
          cur_n   = mem[rp];
`ifdef JT49_BUS_SEQ_READ_EN
          rdop_n  = 1'b0;
        end else if (rd_req && rd_ready) begin
          state_n = LATCH;
          cur_n   = {rd_addr, 8'h00};
          rdop_n  = 1'b1;
`endif
        end
      end
      LATCH: begin
        if (ph == PH_LAST) begin
          state_n = GAP1;
          ph_n    = '0;
        end else begin
          ph_n = ph + PW'(1);
        end
      end
      GAP1: begin
        state_n = WRITE;
`ifdef JT49_BUS_SEQ_READ_EN
        if (rdop) state_n = READ;
`endif
        ph_n = '0;
      end
      WRITE: begin
        if (ph == PH_LAST) begin
          state_n = GAP2;
          ph_n    = '0;
        end else begin
          ph_n = ph + PW'(1);
        end
      end
`ifdef JT49_BUS_SEQ_READ_EN
      READ: begin
        if (ph == PH_LAST) begin
          state_n = GAP2;
          ph_n    = '0;
          rdv_n   = 1'b1;
          rdd_n   = psg_dout;
        end else begin
          ph_n = ph + PW'(1);
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Bus pins follow the state being entered; data bus holds in gaps
  always_comb begin
    bdir_n = 1'b0;
    bc1_n  = 1'b0;
    dout_n = bus_dout;
    unique case (state_n)
      LATCH: begin
        bdir_n = 1'b1;
        bc1_n  = 1'b1;
        dout_n = {4'h0, cur_n[11:8]};
      end
      WRITE: begin
        bdir_n = 1'b1;
        dout_n = cur_n[7:0];
      end
`ifdef JT49_BUS_SEQ_READ_EN
      READ: bc1_n = 1'b1;
`endif
      default: ;
    endcase
  end

  // State, FIFO pointers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ph       <= '0;
      cur      <= '0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      bdir     <= 1'b0;
      bc1      <= 1'b0;
      bus_dout <= 8'h00;
      busy     <= 1'b0;
      wr_ready <= 1'b1;
`ifdef JT49_BUS_SEQ_READ_EN
      rdop     <= 1'b0;
      rd_ready <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
`endif
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      cur      <= cur_n;
      cnt      <= cnt_n;
      if (push) wp <= wp + FIFO_AW'(1);
      if (pop)  rp <= rp + FIFO_AW'(1);
      bdir     <= bdir_n;
      bc1      <= bc1_n;
      bus_dout <= dout_n;
      busy     <= (state_n != IDLE) || (cnt_n != '0);
      wr_ready <= (cnt_n != CNT_FULL);
`ifdef JT49_BUS_SEQ_READ_EN
      rdop     <= rdop_n;
      rd_ready <= (state_n == IDLE) && (cnt_n == '0);
      rd_valid <= rdv_n;
      rd_data  <= rdd_n;
`endif
    end
  end

endmodule

// File: tb/tb_jt49_bus_seq.sv
// tb_jt49_bus_seq: scoreboard bench for the BDIR/BC1 bus sequencer.
// A HOLD=2 and a HOLD=0 instance are both held to one transaction model.
`timescale 1ns/1ps
module tb_jt49_bus_seq;

  localparam int HL    = 2;
  localparam int SEQ   = 2 * HL + 2;
  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_addr  = '0;
  logic [7:0] wr_data  = '0;
  logic       wr_ready0, wr_ready1;
  logic       busy0, busy1;
  logic       bdir0, bdir1;
  logic       bc1_0, bc1_1;
  logic [7:0] dout0, dout1;
`ifdef JT49_BUS_SEQ_READ_EN
  logic       rd_req  = 1'b0;
  logic [3:0] rd_addr = '0;
  logic       rd_ready0, rd_ready1;
  logic       rd_valid0, rd_valid1;
  logic [7:0] rd_data0, rd_data1;
  logic [7:0] psg_dout;
  logic [7:0] psg_regs [16];
  logic [3:0] psg_a = '0;
`endif

  jt49_bus_seq #(.HOLD(2), .FIFO_AW(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready0),
    .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef JT49_BUS_SEQ_READ_EN
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready0),
    .psg_dout(psg_dout), .rd_valid(rd_valid0), .rd_data(rd_data0),
`endif
    .busy(busy0), .bdir(bdir0), .bc1(bc1_0), .bus_dout(dout0)
  );

  jt49_bus_seq #(.HOLD(0), .FIFO_AW(2)) u_h0 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready1),
    .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef JT49_BUS_SEQ_READ_EN
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready1),
    .psg_dout(psg_dout), .rd_valid(rd_valid1), .rd_data(rd_data1),
`endif
    .busy(busy1), .bdir(bdir1), .bc1(bc1_1), .bus_dout(dout1)
  );

  always #5 clk = ~clk;

`ifdef JT49_BUS_SEQ_READ_EN
  // Simple PSG register file driven by the main instance's bus
  always @(posedge clk) begin
    if (bdir0 && bc1_0) psg_a <= dout0[3:0];
    if (bdir0 && !bc1_0) psg_regs[psg_a] <= dout0;
  end
  assign psg_dout = psg_regs[psg_a];
`endif

  typedef struct {
    int         acc;
    int         start;
    bit         rd;
    logic [3:0] addr;
    logic [7:0] data;
  } tr_t;

  tr_t expq[$];
  int  ecnt     = 0;
  int  free_at  = 0;
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string nm, input int id,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d edge %0d: got %h want %h",
               nm, id, ecnt, act, exp);
    end
  endtask

  // Model: one bus sequence per transaction, starting the edge after
  // acceptance or right after the previous sequence, whichever is later.
  task automatic model_write(input logic [3:0] a, input logic [7:0] d,
                             input int acc);
    tr_t t;
    t.acc   = acc;
    t.start = (acc + 1 > free_at) ? acc + 1 : free_at;
    t.rd    = 1'b0;
    t.addr  = a;
    t.data  = d;
    free_at = t.start + SEQ;
    expq.push_back(t);
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (wr_ready0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: wr_ready=%b want 1", wr_ready0);
      wr_valid = 1'b0;
    end else begin
      model_write(a, d, ecnt + 1);
      @(negedge clk);
      wr_valid = 1'b0;
    end
  endtask

`ifdef JT49_BUS_SEQ_READ_EN
  task automatic do_read(input logic [3:0] a);
    int  n;
    tr_t t;
    n = 0;
    rd_req  = 1'b1;
    rd_addr = a;
    while (rd_ready0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL read_timeout: rd_ready=%b want 1", rd_ready0);
      rd_req = 1'b0;
    end else begin
      t.acc   = ecnt + 1;
      t.start = ecnt + 1;
      t.rd    = 1'b1;
      t.addr  = a;
      t.data  = 8'h00;
      free_at = t.start + SEQ;
      expq.push_back(t);
      @(negedge clk);
      rd_req = 1'b0;
    end
  endtask
`endif

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 !== 1'b0 || expq.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL idle_timeout: busy=%b pending=%0d want busy=0 pending=0",
               busy0, expq.size());
    end
  endtask

  // Monitor: after every edge pop transactions whose start has come and
  // compare both instances against the expected bus phase.
  initial begin
    tr_t        cur;
    bit         act_f;
    logic [7:0] last_d;
    logic [7:0] rdd_m;
    logic [7:0] mregs [16];
    logic [9:0] e_bus;
    logic       e_rv;
    int         p, n;
    act_f  = 1'b0;
    last_d = 8'h00;
    rdd_m  = 8'h00;
    cur    = '{default: 0};
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      ecnt++;
      if (!rst_n) begin
        expq.delete();
        act_f  = 1'b0;
        last_d = 8'h00;
        rdd_m  = 8'h00;
      end else begin
        if (act_f && ecnt == cur.start + SEQ) begin
          act_f  = 1'b0;
          last_d = cur.rd ? {4'h0, cur.addr} : cur.data;
          if (!cur.rd) mregs[cur.addr] = cur.data;
        end
        if (expq.size() > 0 && expq[0].start == ecnt) begin
          cur   = expq.pop_front();
          act_f = 1'b1;
        end
      end
      e_bus = {2'b00, last_d};
      e_rv  = 1'b0;
      if (act_f) begin
        p = ecnt - cur.start;
        if (p < HL)
          e_bus = {2'b11, 4'h0, cur.addr};
        else if (p == HL)
          e_bus = {2'b00, 4'h0, cur.addr};
        else if (p <= 2 * HL)
          e_bus = cur.rd ? {2'b01, 4'h0, cur.addr} : {2'b10, cur.data};
        else begin
          e_bus = cur.rd ? {2'b00, 4'h0, cur.addr} : {2'b00, cur.data};
          if (cur.rd) begin
            e_rv  = 1'b1;
            rdd_m = mregs[cur.addr];
          end
        end
      end
      n = 0;
      foreach (expq[i]) if (expq[i].acc <= ecnt) n++;
      chk("bus", 0, 16'({bdir0, bc1_0, dout0}), 16'(e_bus));
      chk("bus", 1, 16'({bdir1, bc1_1, dout1}), 16'(e_bus));
      chk("wr_ready", 0, 16'(wr_ready0), 16'(n < DEPTH));
      chk("wr_ready", 1, 16'(wr_ready1), 16'(n < DEPTH));
      chk("busy", 0, 16'(busy0), 16'(act_f || n > 0));
      chk("busy", 1, 16'(busy1), 16'(act_f || n > 0));
`ifdef JT49_BUS_SEQ_READ_EN
      chk("rd_ready", 0, 16'(rd_ready0), 16'(!act_f && n == 0));
      chk("rd_ready", 1, 16'(rd_ready1), 16'(!act_f && n == 0));
      chk("rd_valid", 0, 16'(rd_valid0), 16'(e_rv));
      chk("rd_valid", 1, 16'(rd_valid1), 16'(e_rv));
      chk("rd_data", 0, 16'(rd_data0), 16'(rdd_m));
      chk("rd_data", 1, 16'(rd_data1), 16'(rdd_m));
`endif
    end
  end

  // Stimulus
  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    push_wr(4'h7, 8'h38);
    wait_idle();

    push_wr(4'h1, 8'h10);
    for (int i = 0; i < 5; i++) push_wr(4'(i + 2), 8'(8'h20 + i));
    wait_idle();

    repeat (60) begin
      repeat ($urandom_range(0, 8)) @(negedge clk);
      push_wr(4'($urandom), 8'($urandom));
    end
    wait_idle();

`ifdef JT49_BUS_SEQ_READ_EN
    push_wr(4'h2, 8'hA5);
    do_read(4'h2);
    push_wr(4'h5, 8'h5A);
    do_read(4'h5);
    wait_idle();
`endif

    push_wr(4'h3, 8'h11);
    push_wr(4'h4, 8'h22);
    n = 0;
    while (!(bdir0 === 1'b1 && bc1_0 === 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL write_phase_timeout: bdir=%b bc1=%b want 1 0",
               bdir0, bc1_0);
    end
    rst_n = 1'b0;
    free_at = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    push_wr(4'h9, 8'h99);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
